// File: rtl/m_mem_arbiter_pkg.sv
// Shared codes and defaults for the IF/data memory arbiter.
// Pure declarations: no latency, no flow control.
package m_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_D  = 1'b0,
    PRI_IF = 1'b1
  } pri_e;

  localparam int ARB_ADDR_W     = 12;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/m_mem_arbiter_if.sv
// Requester + RAM bus of the memory arbiter; slave is the arbiter side.
// Grants are combinational, read data returns one cycle after grant.
interface m_mem_arbiter_if
  import m_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  logic              w_if_req;
  logic [ADDR_W-1:0] w_if_addr;
  logic              w_if_gnt;
  logic              w_if_rvalid;
  logic [DATA_W-1:0] w_if_rdata;

  logic              w_d_req;
  logic              w_d_we;
  logic [ADDR_W-1:0] w_d_addr;
  logic [DATA_W-1:0] w_d_wdata;
  logic              w_d_gnt;
  logic              w_d_rvalid;
  logic [DATA_W-1:0] w_d_rdata;

  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_din;
  logic [DATA_W-1:0] w_mem_dout;

  modport slave (
    input  w_if_req, w_if_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_mem_dout,
    output w_if_gnt, w_if_rvalid, w_if_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
           w_mem_addr, w_mem_we, w_mem_din
  );

  modport master (
    output w_if_req, w_if_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_mem_dout,
    input  w_if_gnt, w_if_rvalid, w_if_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
           w_mem_addr, w_mem_we, w_mem_din
  );
endinterface

// File: rtl/m_mem_arbiter_starve_cnt.sv
// Saturating count of consecutive ungranted IF cycles; o_hit flags the next value reaching MAX.
// Registered count, combinational hit; no flow control.
module m_starve_cnt
  import m_arb_pkg::*;
#(
  parameter int MAX = ARB_STARVE_MAX
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);
  localparam int W = cnt_w(MAX);
  localparam logic [W-1:0] LP_MAX = W'(MAX);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      w_cnt_nxt = r_cnt + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Looking at the next value lets the forced IF grant land in the very next cycle.
  assign o_hit = (w_cnt_nxt == LP_MAX);

endmodule

// File: rtl/m_mem_arbiter.sv
// Shares one single-port RAM between IF (read-only) and data (load/store); data wins unless IF is starving.
// Grant combinational, read response one cycle after grant; losers stall by holding req.
module m_mem_arbiter
  import m_arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  m_mem_arbiter_if.slave  bus
);
  pri_e   r_state;
  owner_e r_owner;

  logic w_if_gnt;
  logic w_d_gnt;
  logic w_inc;
  logic w_clr;
  logic w_hit;

  // Reset gates the grants so nothing reaches the RAM while held in reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (w_rst_n) begin
      if (r_state == PRI_IF) begin
        w_if_gnt = bus.w_if_req;
        w_d_gnt  = bus.w_d_req & ~bus.w_if_req;
      end else begin
        w_d_gnt  = bus.w_d_req;
        w_if_gnt = bus.w_if_req & ~bus.w_d_req;
      end
    end
  end

  assign bus.w_if_gnt   = w_if_gnt;
  assign bus.w_d_gnt    = w_d_gnt;
  assign bus.w_mem_addr = w_if_gnt ? bus.w_if_addr : bus.w_d_addr;
  assign bus.w_mem_we   = w_d_gnt & bus.w_d_we;
  assign bus.w_mem_din  = bus.w_d_wdata;

  assign w_inc = bus.w_if_req & ~w_if_gnt;
  assign w_clr = w_if_gnt | ~bus.w_if_req;

  m_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .i_clk   (w_clk),
    .i_rst_n (w_rst_n),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_hit   (w_hit)
  );

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= PRI_D;
      r_owner <= OWN_NONE;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_d_gnt && !bus.w_d_we) begin
        r_owner <= OWN_D;
      end else begin
        r_owner <= OWN_NONE;
      end

      case (r_state)
        PRI_D:  if (w_hit) r_state <= PRI_IF;
        PRI_IF: if (w_if_gnt || !bus.w_if_req) r_state <= PRI_D;
      endcase
    end
  end

  // Both ports see the RAM output; rvalid tells each requester whether it is theirs.
  assign bus.w_if_rvalid = (r_owner == OWN_IF);
  assign bus.w_d_rvalid  = (r_owner == OWN_D);
  assign bus.w_if_rdata  = bus.w_mem_dout;
  assign bus.w_d_rdata   = bus.w_mem_dout;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Bench for m_mem_arbiter: two instances (STARVE_MAX 4 and 1) share stimulus, each with its own RAM and model.
// The model grants IF when it has waited STARVE_MAX cycles or data is idle, and shadows RAM contents.
`timescale 1ns/1ps
module tb_m_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NI = 2;
  localparam int LN = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic fill;
  always #5 clk = ~clk;

  logic          if_req [NI];
  logic [AW-1:0] if_addr[NI];
  logic          d_req  [NI];
  logic          d_we   [NI];
  logic [AW-1:0] d_addr [NI];
  logic [DW-1:0] d_wdata[NI];
  logic          if_gnt [NI];
  logic          d_gnt  [NI];
  logic          if_rv  [NI];
  logic          d_rv   [NI];
  logic [DW-1:0] if_rd  [NI];
  logic [DW-1:0] d_rd   [NI];
  logic [AW-1:0] mem_addr[NI];
  logic          mem_we [NI];
  logic [DW-1:0] mem_din[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    m_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] ram_q;

    m_mem_arbiter #(.STARVE_MAX(g == 0 ? 4 : 1)) u_dut (
      .w_clk   (clk),
      .w_rst_n (rst_n),
      .bus     (bus)
    );

    assign bus.w_if_req   = if_req[g];
    assign bus.w_if_addr  = if_addr[g];
    assign bus.w_d_req    = d_req[g];
    assign bus.w_d_we     = d_we[g];
    assign bus.w_d_addr   = d_addr[g];
    assign bus.w_d_wdata  = d_wdata[g];
    assign bus.w_mem_dout = ram_q;
    assign if_gnt[g]   = bus.w_if_gnt;
    assign d_gnt[g]    = bus.w_d_gnt;
    assign if_rv[g]    = bus.w_if_rvalid;
    assign d_rv[g]     = bus.w_d_rvalid;
    assign if_rd[g]    = bus.w_if_rdata;
    assign d_rd[g]     = bus.w_d_rdata;
    assign mem_addr[g] = bus.w_mem_addr;
    assign mem_we[g]   = bus.w_mem_we;
    assign mem_din[g]  = bus.w_mem_din;

    // Synchronous RAM, one-cycle read latency, returns old data on a write.
    always @(posedge clk) begin
      if (fill) begin
        for (int a = 0; a < (1<<AW); a++) ram[a] <= DW'(a * 4);
      end else begin
        if (bus.w_mem_we) ram[bus.w_mem_addr] <= bus.w_mem_din;
        ram_q <= ram[bus.w_mem_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int smax(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Model state: IF wait length, pending response owner (0 none, 1 IF, 2 D) and its data.
  logic [DW-1:0] sh [NI][1<<AW];
  int            wt  [NI];
  int            pend[NI];
  logic [DW-1:0] pdat[NI];
  logic          gi  [NI];
  logic          gd  [NI];
  int            lc;
  int            lg  [NI][LN];
  int            lv  [NI][LN];
  logic [DW-1:0] ldat[NI][LN];

  always @(negedge clk) begin
    if (fill) begin
      for (int k = 0; k < NI; k++)
        for (int a = 0; a < (1<<AW); a++) sh[k][a] = DW'(a * 4);
    end
    for (int k = 0; k < NI; k++) begin
      logic          ei, ed;
      logic [AW-1:0] ea;
      ei = rst_n && if_req[k] && (!d_req[k] || wt[k] >= smax(k));
      ed = rst_n && d_req[k] && !ei;
      ea = ei ? if_addr[k] : d_addr[k];
      chk($sformatf("if_gnt[%0d]", k), 32'(if_gnt[k]), 32'(ei));
      chk($sformatf("d_gnt[%0d]", k), 32'(d_gnt[k]), 32'(ed));
      chk($sformatf("mem_we[%0d]", k), 32'(mem_we[k]), 32'(ed && d_we[k]));
      chk($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), 32'(ea));
      if (ed && d_we[k]) chk($sformatf("mem_din[%0d]", k), mem_din[k], d_wdata[k]);
      chk($sformatf("if_rvalid[%0d]", k), 32'(if_rv[k]), 32'(rst_n && pend[k] == 1));
      chk($sformatf("d_rvalid[%0d]", k), 32'(d_rv[k]), 32'(rst_n && pend[k] == 2));
      if (rst_n && pend[k] == 1) chk($sformatf("if_rdata[%0d]", k), if_rd[k], pdat[k]);
      if (rst_n && pend[k] == 2) chk($sformatf("d_rdata[%0d]", k), d_rd[k], pdat[k]);
      if (lc < LN) begin
        lg[k][lc]   = ei ? 1 : (ed ? 2 : 0);
        lv[k][lc]   = {30'd0, if_rv[k], d_rv[k]};
        ldat[k][lc] = if_rv[k] ? if_rd[k] : d_rd[k];
      end
      if (!rst_n) begin
        pend[k] = 0;
        wt[k]   = 0;
      end else begin
        pend[k] = ei ? 1 : ((ed && !d_we[k]) ? 2 : 0);
        pdat[k] = sh[k][ea];
        if (ed && d_we[k]) sh[k][d_addr[k]] = d_wdata[k];
        wt[k] = (if_req[k] && !ei) ? wt[k] + 1 : 0;
      end
      gi[k] = ei;
      gd[k] = ed;
    end
    lc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    for (int k = 0; k < NI; k++) begin
      if_req[k]  = ir;
      if_addr[k] = ia;
      d_req[k]   = dr;
      d_we[k]    = dw;
      d_addr[k]  = da;
      d_wdata[k] = dd;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
  endfunction

  int pat0[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int pat1[10] = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};

  initial begin
    lc    = 0;
    rst_n = 1'b0;
    fill  = 1'b1;
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    fill  = 1'b0;
    rst_n = 1'b1;
    step();

    // IF alone streams addresses 0..3
    lc = 0;
    for (int i = 0; i < 4; i++) begin
      set_all(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
      step();
    end
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_grant[%0d][%0d]", k, i), lg[k][i], 1);
        chk($sformatf("t1_rvalid[%0d][%0d]", k, i), lv[k][i+1], 2);
        chk($sformatf("t1_rdata[%0d][%0d]", k, i), ldat[k][i+1], 32'(i * 4));
      end

    // Store then load of the same word on consecutive cycles
    lc = 0;
    set_all(1'b0, '0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    step();
    set_all(1'b0, '0, 1'b1, 1'b0, 12'h010, '0);
    step();
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("t3_store_norv[%0d]", k), lv[k][1], 0);
      chk($sformatf("t3_load_rv[%0d]", k), lv[k][2], 1);
      chk($sformatf("t3_load_data[%0d]", k), ldat[k][2], 32'hDEADBEEF);
    end

    // Both request continuously: starvation guard interleaves IF
    lc = 0;
    for (int c = 0; c < 10; c++) begin
      set_all(1'b1, 12'h020, 1'b1, 1'b0, 12'h030, '0);
      step();
    end
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t2_grant0[%0d]", c), lg[0][c], pat0[c]);
      chk($sformatf("t5_grant1[%0d]", c), lg[1][c], pat1[c]);
      chk($sformatf("t2_rvalid0[%0d]", c), lv[0][c+1], (pat0[c] == 1) ? 2 : 1);
      chk($sformatf("t5_rvalid1[%0d]", c), lv[1][c+1], (pat1[c] == 1) ? 2 : 1);
    end

    // IF drops after 3 waits; the re-request waits the full 4 cycles again
    lc = 0;
    for (int c = 0; c < 9; c++) begin
      set_all(c != 3, 12'h040, 1'b1, 1'b0, 12'h050, '0);
      step();
    end
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();
    for (int c = 0; c < 8; c++) chk($sformatf("t6_dgrant[%0d]", c), lg[0][c], 2);
    chk("t6_ifgrant", lg[0][8], 1);

    // Load granted, then reset asserted at that cycle's closing edge
    lc = 0;
    set_all(1'b0, '0, 1'b1, 1'b0, 12'h010, '0);
    @(posedge clk);
    rst_n = 1'b0;
    set_all(1'b1, 12'h020, 1'b1, 1'b0, 12'h030, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("t4_pre_grant[%0d]", k), lg[k][0], 2);
      chk($sformatf("t4_rst_norv[%0d]", k), lv[k][1], 0);
      chk($sformatf("t4_rst_nognt[%0d]", k), lg[k][1], 0);
      chk($sformatf("t4_rel_norv[%0d]", k), lv[k][3], 0);
      chk($sformatf("t4_rel_dpri[%0d]", k), lg[k][3], 2);
      chk($sformatf("t4_rel_rv[%0d]", k), lv[k][4], 1);
      chk($sformatf("t4_rel_data[%0d]", k), ldat[k][4], 32'h0000_00C0);
    end

    // Random traffic: requests held until granted, occasionally withdrawn
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!(if_req[k] && !gi[k]) || $urandom_range(0, 19) == 0) begin
          if_req[k]  = ($urandom_range(0, 9) < 6);
          if_addr[k] = rnd_addr();
        end
        if (!(d_req[k] && !gd[k]) || $urandom_range(0, 19) == 0) begin
          d_req[k]   = ($urandom_range(0, 9) < 5);
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = rnd_addr();
          d_wdata[k] = $urandom;
        end
      end
      step();
    end
    set_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
